tri_sum_sched: RTL and testbench

// - Shares one triangular-sum engine (x<=x+y, y<=y+1 while y<limit; x=1,y=0 at load) among NREQ requesters.
// - Round-robin arbiter accepts a job {limit}, loads the engine, sequences its steps, returns {x,y,ovf} on a valid/ready response.
// - Sits between requester agents and the shared arithmetic datapath; exactly one job in flight at a time.

---
 rtl/tri_sum_pkg.sv | 27 ++
 rtl/tri_sum_sched_if.sv | 33 +++
 rtl/tri_sum_engine.sv | 39 +++
 rtl/tri_sum_sched.sv | 129 ++++++++++++
 tb/tb_tri_sum_sched.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tri_sum_pkg.sv
// Shared types and defaults for the triangular-sum scheduler slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tri_sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int TRI_NREQ = 4;
  localparam int TRI_LW   = 10;
  localparam int TRI_XW   = 24;

  // Closed form of the engine result: 1 + limit*(limit-1)/2, wrapped to xw bits.
  function automatic logic [63:0] tri_sum_ref(input int unsigned limit, input int unsigned xw);
    logic [63:0] l;
    logic [63:0] full;
    l    = 64'(limit);
    full = 64'd1 + ((l * (l - 64'd1)) >> 1);
    if (xw >= 64) return full;
    return full & ((64'd1 << xw) - 64'd1);
  endfunction

endpackage

// File: rtl/tri_sum_sched_if.sv
// Request/response bundle between requester agents and the scheduler.
// Latency: none (wiring only).
// Backpressure: req_ready one-hot accept, rsp_valid held until rsp_ready.
interface tri_sum_sched_if #(
  parameter int NREQ = 4,
  parameter int LW   = 10,
  parameter int XW   = 24
) ();
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*LW-1:0] req_limit;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [XW-1:0]      rsp_x;
  logic [LW-1:0]      rsp_y;
  logic               rsp_ovf;
  logic               busy;

  // Requesters and the response consumer.
  modport master (
    output req_valid, req_limit, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_ovf, busy
  );

  // The scheduler itself.
  modport slave (
    input  req_valid, req_limit, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_ovf, busy
  );
endinterface

// File: rtl/tri_sum_engine.sv
// Triangular-sum datapath: x<=x+y, y<=y+1 per step; load restarts at x=1,y=0.
// Latency: one cycle per load or step; below reflects current y.
// Backpressure: none; steps only when the controller asserts step.
module tri_sum_engine #(
  parameter int LW = 10,
  parameter int XW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [LW-1:0] limit,
  output logic [XW-1:0] x,
  output logic [LW-1:0] y,
  output logic          ovf,
  output logic          below
);
  localparam int SW = XW + 1;

  // One extra bit keeps the carry-out of each accumulation visible.
  logic [SW-1:0] sum;

  assign sum   = {1'b0, x} + SW'(y);
  assign below = (y < limit);

  // Accumulator registers; ovf is sticky until the next load.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      x   <= XW'(1);
      y   <= '0;
      ovf <= 1'b0;
    end else if (step) begin
      x   <= sum[XW-1:0];
      y   <= y + LW'(1);
      ovf <= ovf | sum[XW];
    end
  end

endmodule

// File: rtl/tri_sum_sched.sv
// Round-robin front end sharing one triangular-sum engine; optional step_en under TRI_SUM_STALL_EN.
// Latency: accept in cycle c -> rsp_valid in cycle c+limit+3 (more if steps are stalled).
// Backpressure: one job in flight; response held until rsp_ready, next accept the cycle after.
module tri_sum_sched
  import tri_sum_pkg::*;
#(
  parameter int NREQ = TRI_NREQ,
  parameter int LW   = TRI_LW,
  parameter int XW   = TRI_XW
) (
  input  logic clk,
  input  logic rst,
`ifdef TRI_SUM_STALL_EN
  input  logic step_en,
`endif
  tri_sum_sched_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] job_id;
  logic [LW-1:0]  job_limit;
  logic           rsp_valid_q;
  logic           busy_q;

  logic           any_req;
  logic [IDW-1:0] win_id;
  logic [NREQ-1:0] ready_vec;
  logic           step_go;
  logic           eng_load;
  logic           eng_step;
  logic           eng_below;
  logic [XW-1:0]  eng_x;
  logic [LW-1:0]  eng_y;
  logic           eng_ovf;

`ifdef TRI_SUM_STALL_EN
  assign step_go = step_en;
`else
  assign step_go = 1'b1;
`endif

  // Round-robin pick: first asserted request at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    any_req = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!any_req && bus.req_valid[idx]) begin
        any_req = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  // Accept is combinational so the winner sees ready in the same cycle.
  always_comb begin
    ready_vec = '0;
    if (state == IDLE && any_req) ready_vec[win_id] = 1'b1;
  end

  assign eng_load = (state == LOAD);
  assign eng_step = (state == RUN) && eng_below && step_go;

  tri_sum_engine #(.LW(LW), .XW(XW)) u_engine (
    .clk   (clk),
    .rst   (rst),
    .load  (eng_load),
    .step  (eng_step),
    .limit (job_limit),
    .x     (eng_x),
    .y     (eng_y),
    .ovf   (eng_ovf),
    .below (eng_below)
  );

  // Job sequencing, arbitration pointer and registered response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      job_id      <= '0;
      job_limit   <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            job_id    <= win_id;
            job_limit <= bus.req_limit[win_id*LW +: LW];
            state     <= LOAD;
            busy_q    <= 1'b1;
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          // Completion does not wait for step_en, so limit 0 never stalls.
          if (!eng_below) begin
            state       <= DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr      <= (job_id == IDW'(NREQ - 1)) ? '0 : job_id + IDW'(1);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Engine registers are held in DONE, so they double as the response payload.
  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = job_id;
  assign bus.rsp_x     = eng_x;
  assign bus.rsp_y     = eng_y;
  assign bus.rsp_ovf   = eng_ovf;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_tri_sum_sched.sv
// Directed bench for tri_sum_sched: default instance plus an XW=16 instance for wrap.
// Latency: measured from accept cycle to first rsp_valid.
// Backpressure: exercises rsp_ready held low and back-to-back round-robin jobs.
module tb_tri_sum_sched;
  import tri_sum_pkg::*;

  localparam int NREQ = 4;
  localparam int LW   = 10;

  logic clk = 1'b0;
  logic rst;
`ifdef TRI_SUM_STALL_EN
  logic step_en;
`endif

  always #5 clk = ~clk;

  tri_sum_sched_if #(.NREQ(NREQ), .LW(LW), .XW(24)) if0 ();
  tri_sum_sched_if #(.NREQ(NREQ), .LW(LW), .XW(16)) if1 ();

  tri_sum_sched #(.NREQ(NREQ), .LW(LW), .XW(24)) u0 (
    .clk     (clk),
    .rst     (rst),
`ifdef TRI_SUM_STALL_EN
    .step_en (step_en),
`endif
    .bus     (if0.slave)
  );

  tri_sum_sched #(.NREQ(NREQ), .LW(LW), .XW(16)) u1 (
    .clk     (clk),
    .rst     (rst),
`ifdef TRI_SUM_STALL_EN
    .step_en (step_en),
`endif
    .bus     (if1.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Present a job on if0 and return at the negedge after the accept cycle.
  task automatic accept0(input int id, input int lim);
    int t;
    t = 0;
    if0.req_limit[id*LW +: LW] = LW'(lim);
    if0.req_valid[id] = 1'b1;
    #1;
    while (!if0.req_ready[id] && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("accept", 64'(if0.req_ready[id]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    if0.req_valid[id] = 1'b0;
  endtask

  // Cycles from the accept cycle until rsp_valid is seen (called one cycle after accept).
  task automatic wait0(output int lat);
    lat = 1;
    while (!if0.rsp_valid && lat < 1100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic handshake0();
    if0.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if0.rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int t;
    logic [23:0] px;
    logic [LW-1:0] py;
    logic se;

    if0.req_valid = '0; if0.req_limit = '0; if0.rsp_ready = 1'b0;
    if1.req_valid = '0; if1.req_limit = '0; if1.rsp_ready = 1'b0;
`ifdef TRI_SUM_STALL_EN
    step_en = 1'b1;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset values
    check("rst_busy",  64'(if0.busy),      64'd0);
    check("rst_valid", 64'(if0.rsp_valid), 64'd0);
    check("rst_id",    64'(if0.rsp_id),    64'd0);
    check("rst_x",     64'(if0.rsp_x),     64'd1);
    check("rst_y",     64'(if0.rsp_y),     64'd0);
    check("rst_ovf",   64'(if0.rsp_ovf),   64'd0);
    check("rst_ready", 64'(if0.req_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // All four requesters held high, limit 5: ids 0,1,2,3,0, each x=11
    for (int i = 0; i < NREQ; i++) if0.req_limit[i*LW +: LW] = LW'(5);
    if0.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      t = 0;
      while (!if0.rsp_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("rr_id", 64'(if0.rsp_id), 64'(k % 4));
      check("rr_x",  64'(if0.rsp_x),  64'd11);
      check("rr_y",  64'(if0.rsp_y),  64'd5);
      handshake0();
      if (k < 4) begin
        #1;
        check("rr_next_ready", 64'(if0.req_ready), 64'(1) << ((k + 1) % 4));
        check("rr_no_overlap", 64'(if0.rsp_valid), 64'd0);
      end else begin
        if0.req_valid = '0;
      end
    end
    @(negedge clk);
    check("drop_no_job", 64'(if0.busy), 64'd0);
    @(negedge clk);
    check("drop_no_job2", 64'(if0.busy), 64'd0);

    // Single req0, limit 300
    accept0(0, 300);
    wait0(lat);
    check("l300_lat", 64'(lat),          64'd303);
    check("l300_x",   64'(if0.rsp_x),    64'd44851);
    check("l300_y",   64'(if0.rsp_y),    64'd300);
    check("l300_ovf", 64'(if0.rsp_ovf),  64'd0);
    check("l300_id",  64'(if0.rsp_id),   64'd0);
    check("l300_busy", 64'(if0.busy),    64'd1);
    handshake0();
    check("l300_clear", 64'(if0.rsp_valid), 64'd0);

    // req1, limit 0
    accept0(1, 0);
    wait0(lat);
    check("l0_lat", 64'(lat),        64'd3);
    check("l0_x",   64'(if0.rsp_x),  64'd1);
    check("l0_y",   64'(if0.rsp_y),  64'd0);
    check("l0_id",  64'(if0.rsp_id), 64'd1);
    handshake0();

    // Reset in RUN at y=50
    accept0(0, 300);
    t = 0;
    while (if0.rsp_y != LW'(50) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("mid_y50", 64'(if0.rsp_y), 64'd50);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_busy",  64'(if0.busy),      64'd0);
    check("mid_valid", 64'(if0.rsp_valid), 64'd0);
    check("mid_x",     64'(if0.rsp_x),     64'd1);
    check("mid_y",     64'(if0.rsp_y),     64'd0);
    rst = 1'b0;
    @(negedge clk);
    accept0(2, 3);
    wait0(lat);
    check("post_lat", 64'(lat),        64'd6);
    check("post_x",   64'(if0.rsp_x),  tri_sum_ref(3, 24));
    check("post_id",  64'(if0.rsp_id), 64'd2);
    handshake0();

    // XW=16 instance, limit 400: wraps to 14265 with ovf, held under backpressure
    if1.req_limit[0 +: LW] = LW'(400);
    if1.req_valid[0] = 1'b1;
    #1;
    check("w16_accept", 64'(if1.req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    if1.req_valid[0] = 1'b0;
    lat = 1;
    while (!if1.rsp_valid && lat < 600) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("w16_lat", 64'(lat),         64'd403);
    check("w16_x",   64'(if1.rsp_x),   64'd14265);
    check("w16_y",   64'(if1.rsp_y),   64'd400);
    check("w16_ovf", 64'(if1.rsp_ovf), 64'd1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("w16_hold", 64'({if1.rsp_valid, if1.rsp_x, if1.rsp_y, if1.rsp_ovf}),
            64'({1'b1, 16'd14265, 10'd400, 1'b1}));
    end
    if1.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.rsp_ready = 1'b0;
    check("w16_clear", 64'(if1.rsp_valid), 64'd0);

`ifdef TRI_SUM_STALL_EN
    // Stalled stepping: step_en alternates, x/y hold on stalled cycles
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step_en = 1'b1;
    accept0(3, 4);
    t = 0;
    while (!if0.rsp_valid && t < 40) begin
      px = if0.rsp_x;
      py = if0.rsp_y;
      se = step_en;
      @(posedge clk);
      @(negedge clk);
      if (!se) begin
        check("stall_x_hold", 64'(if0.rsp_x), 64'(px));
        check("stall_y_hold", 64'(if0.rsp_y), 64'(py));
      end
      step_en = ~step_en;
      t++;
    end
    check("stall_valid", 64'(if0.rsp_valid), 64'd1);
    check("stall_x",     64'(if0.rsp_x),     64'd7);
    check("stall_y",     64'(if0.rsp_y),     64'd4);
    step_en = 1'b1;
    handshake0();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
